ip_hdr_check: RTL and testbench
===============================

# ip_hdr_check

Receive-side IPv4 header verifier. Consumes the IP header byte stream from the MAC RX parser (first byte = version/IHL). It accumulates the header as 16-bit words using one's-complement addition with end-around carry, checks that the sum including the checksum field equals 16'hFFFF, and extracts the header fields the UDP RX path needs. Its result gates acceptance of the frame by the downstream UDP parser.

## Interface
- No parameters.
- clk  in  1  system clock (GMII RX clock domain)
- rst_n  in  1  asynchronous, active-low reset
- ip_sof  in  1  qualifies the current byte as header byte 0; only sampled when ip_byte_en=1
- ip_byte_en  in  1  ip_byte is valid this cycle
- ip_byte  in  8  header byte, network order
- hdr_done  out  1  one-cycle pulse: header fully processed or rejected
- chk_ok  out  1  valid with hdr_done; 1 = version 4, IHL ≥ 5, checksum correct
- hdr_err  out  1  valid with hdr_done; 1 = version ≠ 4 or IHL < 5
- ip_hdr_len  out  4  IHL field
- ip_total_len  out  16  total length field
- ip_protocol  out  8  protocol field
- src_ip  out  32  source address
- dst_ip  out  32  destination address

## Operation
- States: IDLE, HDR, DROP.
- IDLE:
  - ip_byte_en & ip_sof: byte index = 0; latch ip_hdr_len = byte[3:0].
  - If byte[7:4] = 4 and byte[3:0] ≥ 5: go to HDR.
  - Otherwise go to DROP. hdr_done=1, hdr_err=1, chk_ok=0 on the next cycle.
- HDR:
  - Each accepted byte increments a 6-bit byte index (maximum 59).
  - Even index: byte is latched as the high half of a word.
  - Odd index: word = {hi, byte}. acc17 = acc + word; acc ← acc17[15:0] + acc17[16].
  - Field capture by byte index:
    - 2–3 → ip_total_len
    - 9 → ip_protocol
    - 12–15 → src_ip
    - 16–19 → dst_ip
  - Last byte (index = IHL*4−1): compute the final folded sum from that word. Register chk_ok = (sum == 16'hFFFF), hdr_err=0, hdr_done=1. Return to IDLE.
- DROP: ignore bytes until the next ip_sof, then process it exactly as in IDLE.
- acc is cleared to 0 when byte 0 is accepted. Byte 0 is also the high half of word 0.
- Bytes with ip_byte_en=0 are ignored. Gaps of any length are allowed.
- Options bytes (index ≥ 20) are summed but not otherwise decoded.

## Timing
- Reset values:
  - hdr_done=0, chk_ok=0, hdr_err=0.
  - All field outputs 0; acc=0; state IDLE.
- Latency: hdr_done is asserted in the cycle after the clock edge that samples the last header byte, or byte 0 for a rejected header. It is high for exactly one cycle.
- chk_ok and hdr_err are registered together with hdr_done and hold until the next hdr_done.
- Field outputs update as their bytes arrive. They are stable from hdr_done until byte 0 of the next header.
- ip_sof while in HDR aborts the current header: no hdr_done is produced for it, and the sof byte restarts at index 0.
- ip_sof=1 with ip_byte_en=0 is ignored.
- rst_n low mid-header returns to reset values immediately. No hdr_done is produced.
- Back-to-back headers: ip_sof on the cycle after the last byte is accepted normally. hdr_done for the previous header fires in that same cycle.

## Test plan
- Valid header, one byte per cycle: 45 00 00 73 00 00 40 00 40 11 b8 61 c0 a8 00 01 c0 a8 00 c7.
  - hdr_done 1 cycle after byte 19; chk_ok=1, hdr_err=0.
  - ip_total_len=0x0073, ip_protocol=0x11, src_ip=0xC0A80001, dst_ip=0xC0A800C7.
- Same header with the checksum changed to b8 62: hdr_done with chk_ok=0, hdr_err=0.
- Same valid header with random 0–3 cycle ip_byte_en gaps: identical results. hdr_done 1 cycle after the last byte.
- Byte 0 = 0x65 (version 6), then byte 0 = 0x44 (IHL 4):
  - Each gives hdr_done the next cycle with hdr_err=1, chk_ok=0.
  - The following 19 bytes produce no further hdr_done.
- IHL=6 header (0x46, 24 bytes) with 4 option bytes 01 01 01 01 and a checksum recomputed to include them: hdr_done after byte 23 with chk_ok=1. A corrupted option byte gives chk_ok=0.
- Abort and reset:
  - ip_sof at byte 10 of a header, followed by a full valid header: exactly one hdr_done, with chk_ok=1.
  - rst_n pulsed at byte 8: all outputs 0 and no hdr_done.

Source files
------------

// File: rtl/ip_hdr_check_if.sv
// Header byte stream from the MAC RX parser plus the verdict and extracted fields returned to the UDP RX path.
interface ip_hdr_check_if;
  logic        ip_sof;
  logic        ip_byte_en;
  logic [7:0]  ip_byte;
  logic        hdr_done;
  logic        chk_ok;
  logic        hdr_err;
  logic [3:0]  ip_hdr_len;
  logic [15:0] ip_total_len;
  logic [7:0]  ip_protocol;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;

  modport master (
    output ip_sof, ip_byte_en, ip_byte,
    input  hdr_done, chk_ok, hdr_err, ip_hdr_len, ip_total_len, ip_protocol, src_ip, dst_ip
  );

  modport slave (
    input  ip_sof, ip_byte_en, ip_byte,
    output hdr_done, chk_ok, hdr_err, ip_hdr_len, ip_total_len, ip_protocol, src_ip, dst_ip
  );
endinterface

// File: rtl/ip_hdr_check.sv
// IPv4 header verifier: one's-complement checksum plus version/IHL check, hdr_done one cycle after the last byte.
// No backpressure: every enabled byte is consumed, gaps of any length are tolerated.
module ip_hdr_check (
  input  logic         clk,
  input  logic         rst_n,
  ip_hdr_check_if.slave hif
);

  typedef enum logic [1:0] {IDLE, HDR, DROP} state_t;

  state_t      state, state_nxt;
  logic [5:0]  idx;        // index of the next byte expected
  logic [5:0]  last_idx;
  logic [7:0]  hi_byte;
  logic [15:0] acc;
  logic [16:0] acc17;
  logic [15:0] acc_fold;
  logic        start, ver_ok, take, last;
  logic        done_nxt, ok_nxt, err_nxt;

  logic        hdr_done_q, chk_ok_q, hdr_err_q;
  logic [3:0]  hdr_len_q;
  logic [15:0] total_len_q;
  logic [7:0]  protocol_q;
  logic [31:0] src_ip_q, dst_ip_q;

  assign start    = hif.ip_byte_en & hif.ip_sof;
  assign ver_ok   = (hif.ip_byte[7:4] == 4'd4) && (hif.ip_byte[3:0] >= 4'd5);
  assign take     = hif.ip_byte_en & ~hif.ip_sof & (state == HDR);
  assign last_idx = {hdr_len_q, 2'b00} - 6'd1;
  assign last     = take && (idx == last_idx);
  assign acc17    = {1'b0, acc} + {1'b0, hi_byte, hif.ip_byte};
  assign acc_fold = acc17[15:0] + {15'd0, acc17[16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A sof byte restarts parsing from any state, which also covers abort-in-HDR.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE, DROP: begin
        if (start) begin
          state_nxt = ver_ok ? HDR : DROP;
          done_nxt  = ~ver_ok;
          err_nxt   = ~ver_ok;
        end
      end
      HDR: begin
        if (start) begin
          state_nxt = ver_ok ? HDR : DROP;
          done_nxt  = ~ver_ok;
          err_nxt   = ~ver_ok;
        end else if (last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ok_nxt    = (acc_fold == 16'hFFFF);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 6'd0;
      hi_byte     <= 8'd0;
      acc         <= 16'd0;
      hdr_done_q  <= 1'b0;
      chk_ok_q    <= 1'b0;
      hdr_err_q   <= 1'b0;
      hdr_len_q   <= 4'd0;
      total_len_q <= 16'd0;
      protocol_q  <= 8'd0;
      src_ip_q    <= 32'd0;
      dst_ip_q    <= 32'd0;
    end else begin
      hdr_done_q <= done_nxt;
      if (done_nxt) begin
        chk_ok_q  <= ok_nxt;
        hdr_err_q <= err_nxt;
      end
      if (start) begin
        idx       <= 6'd1;
        hi_byte   <= hif.ip_byte;
        acc       <= 16'd0;
        hdr_len_q <= hif.ip_byte[3:0];
      end else if (take) begin
        idx <= idx + 6'd1;
        if (!idx[0]) hi_byte <= hif.ip_byte;
        else         acc     <= acc_fold;
        case (idx)
          6'd2:    total_len_q[15:8] <= hif.ip_byte;
          6'd3:    total_len_q[7:0]  <= hif.ip_byte;
          6'd9:    protocol_q        <= hif.ip_byte;
          6'd12:   src_ip_q[31:24]   <= hif.ip_byte;
          6'd13:   src_ip_q[23:16]   <= hif.ip_byte;
          6'd14:   src_ip_q[15:8]    <= hif.ip_byte;
          6'd15:   src_ip_q[7:0]     <= hif.ip_byte;
          6'd16:   dst_ip_q[31:24]   <= hif.ip_byte;
          6'd17:   dst_ip_q[23:16]   <= hif.ip_byte;
          6'd18:   dst_ip_q[15:8]    <= hif.ip_byte;
          6'd19:   dst_ip_q[7:0]     <= hif.ip_byte;
          default: ;
        endcase
      end
    end
  end

  assign hif.hdr_done     = hdr_done_q;
  assign hif.chk_ok       = chk_ok_q;
  assign hif.hdr_err      = hdr_err_q;
  assign hif.ip_hdr_len   = hdr_len_q;
  assign hif.ip_total_len = total_len_q;
  assign hif.ip_protocol  = protocol_q;
  assign hif.src_ip       = src_ip_q;
  assign hif.dst_ip       = dst_ip_q;

endmodule

// File: tb/tb_ip_hdr_check.sv
// Directed bench for ip_hdr_check: valid/corrupt headers, gaps, rejects, options, abort, reset.
module tb_ip_hdr_check;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   d0;
  logic [7:0]   pkt [60];
  logic [159:0] base_hdr;

  always #5 clk = ~clk;

  ip_hdr_check_if hif ();
  ip_hdr_check dut (.clk(clk), .rst_n(rst_n), .hif(hif));

  always @(negedge clk) if (hif.hdr_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic load_base();
    base_hdr = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
    for (int i = 0; i < 20; i++) pkt[i] = base_hdr[159-8*i -: 8];
  endtask

  task automatic drive_byte(input logic sof, input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    hif.ip_byte_en = 1'b1;
    hif.ip_sof     = sof;
    hif.ip_byte    = b;
    @(posedge clk);
    #1;
    hif.ip_byte_en = 1'b0;
    hif.ip_sof     = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int maxgap);
    for (int i = 0; i < n; i++)
      drive_byte(i == 0, pkt[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Samples the cycle right after the last byte's sampling edge.
  task automatic check_done(input string tag, input logic ok, input logic err);
    @(negedge clk);
    check({tag, "_done"}, hif.hdr_done, 1'b1);
    check({tag, "_ok"},   hif.chk_ok,   ok);
    check({tag, "_err"},  hif.hdr_err,  err);
  endtask

  task automatic check_fields(input string tag, input logic [3:0] ihl);
    check({tag, "_ihl"},   hif.ip_hdr_len,   ihl);
    check({tag, "_tlen"},  hif.ip_total_len, 16'h0073);
    check({tag, "_proto"}, hif.ip_protocol,  8'h11);
    check({tag, "_src"},   hif.src_ip,       32'hC0A80001);
    check({tag, "_dst"},   hif.dst_ip,       32'hC0A800C7);
  endtask

  task automatic check_count(input string tag, input int exp);
    repeat (3) @(negedge clk);
    check(tag, done_cnt - d0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    hif.ip_sof = 1'b0; hif.ip_byte_en = 1'b0; hif.ip_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done", hif.hdr_done, 1'b0);
    check("rst_ok", hif.chk_ok, 1'b0);
    check("rst_err", hif.hdr_err, 1'b0);
    check("rst_tlen", hif.ip_total_len, 16'h0);
    check("rst_src", hif.src_ip, 32'h0);
    check("rst_dst", hif.dst_ip, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Valid header, one byte per cycle
    load_base(); d0 = done_cnt;
    send_pkt(20, 0);
    check_done("valid", 1'b1, 1'b0);
    check_fields("valid", 4'd5);
    @(negedge clk);
    check("valid_pulse", hif.hdr_done, 1'b0);
    check_count("valid_cnt", 1);

    // Corrupted checksum
    load_base(); pkt[11] = 8'h62; d0 = done_cnt;
    send_pkt(20, 0);
    check_done("badsum", 1'b0, 1'b0);
    check_count("badsum_cnt", 1);

    // Random gaps
    load_base(); d0 = done_cnt;
    send_pkt(20, 3);
    check_done("gaps", 1'b1, 1'b0);
    check_fields("gaps", 4'd5);
    check_count("gaps_cnt", 1);

    // Version 6, then IHL 4, each followed by the rest of a header
    load_base(); d0 = done_cnt;
    drive_byte(1'b1, 8'h65, 0);
    check_done("ver6", 1'b0, 1'b1);
    for (int i = 1; i < 20; i++) drive_byte(1'b0, pkt[i], 0);
    check_count("ver6_cnt", 1);
    d0 = done_cnt;
    drive_byte(1'b1, 8'h44, 0);
    check_done("ihl4", 1'b0, 1'b1);
    check("ihl4_len", hif.ip_hdr_len, 4'd4);
    for (int i = 1; i < 20; i++) drive_byte(1'b0, pkt[i], 0);
    check_count("ihl4_cnt", 1);

    // IHL 6 with four option bytes
    load_base(); pkt[0] = 8'h46; pkt[10] = 8'hb5; pkt[11] = 8'h5f;
    for (int i = 20; i < 24; i++) pkt[i] = 8'h01;
    d0 = done_cnt;
    send_pkt(24, 0);
    check_done("opt", 1'b1, 1'b0);
    check_fields("opt", 4'd6);
    check_count("opt_cnt", 1);
    pkt[23] = 8'h02; d0 = done_cnt;
    send_pkt(24, 0);
    check_done("optbad", 1'b0, 1'b0);
    check_count("optbad_cnt", 1);

    // Abort at byte 10, then a full valid header
    load_base(); d0 = done_cnt;
    for (int i = 0; i < 10; i++) drive_byte(i == 0, pkt[i], 0);
    send_pkt(20, 0);
    check_done("abort", 1'b1, 1'b0);
    check_count("abort_cnt", 1);

    // Back-to-back: next sof in the hdr_done cycle
    load_base(); d0 = done_cnt;
    send_pkt(20, 0);
    hif.ip_byte_en = 1'b1; hif.ip_sof = 1'b1; hif.ip_byte = pkt[0];
    check_done("b2b_a", 1'b1, 1'b0);
    @(posedge clk); #1;
    hif.ip_byte_en = 1'b0; hif.ip_sof = 1'b0;
    for (int i = 1; i < 20; i++) drive_byte(1'b0, pkt[i], 0);
    check_done("b2b_b", 1'b1, 1'b0);
    check_count("b2b_cnt", 2);

    // Reset pulsed at byte 8
    load_base(); d0 = done_cnt;
    for (int i = 0; i < 8; i++) drive_byte(i == 0, pkt[i], 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_done", hif.hdr_done, 1'b0);
    check("mrst_ok", hif.chk_ok, 1'b0);
    check("mrst_ihl", hif.ip_hdr_len, 4'd0);
    check("mrst_tlen", hif.ip_total_len, 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 8; i < 20; i++) drive_byte(1'b0, pkt[i], 0);
    check_count("mrst_cnt", 0);
    d0 = done_cnt;
    send_pkt(20, 0);
    check_done("post_rst", 1'b1, 1'b0);
    check_count("post_rst_cnt", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
